// File: rtl/mux_arb_reg_pkg.sv
// Shared constants and helpers for the arbitrating output-register mux.
// The default datapath width and channel count live here so every user agrees.
package mux_arb_reg_pkg;

    localparam int ARCH_WIDTH   = 64;
    localparam int DEFAULT_N_CH = 4;

    // Index width needed to name n distinct items (n >= 2 in practice).
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int v = n - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mux_arb_reg_grant.sv
// Combinational grant picker: starting at ptr_i, scan channels in circular order
// and return the first eligible one as a one-hot grant plus its encoded index.
module mux_arb_grant
    import mux_arb_reg_pkg::*;
#(
    parameter int N_CH  = DEFAULT_N_CH,
    parameter int SEL_W = clog2(N_CH)
) (
    input  logic [N_CH-1:0]  elig_i,
    input  logic [SEL_W-1:0] ptr_i,
    output logic [N_CH-1:0]  grant_o,
    output logic [SEL_W-1:0] idx_o
);

    always_comb begin
        logic             found;
        logic [SEL_W:0]   cand;
        logic [SEL_W-1:0] cand_idx;
        found    = 1'b0;
        cand     = '0;
        cand_idx = '0;
        grant_o  = '0;
        idx_o    = '0;
        for (int j = 0; j < N_CH; j++) begin
            // Rotate by the pointer; the wrap is modulo N_CH, not 2**SEL_W.
            cand = {1'b0, ptr_i} + (SEL_W+1)'(j);
            if (cand >= (SEL_W+1)'(N_CH)) begin
                cand = cand - (SEL_W+1)'(N_CH);
            end
            cand_idx = cand[SEL_W-1:0];
            if (!found && elig_i[cand_idx]) begin
                found             = 1'b1;
                grant_o[cand_idx] = 1'b1;
                idx_o             = cand_idx;
            end
        end
    end

endmodule

// File: rtl/mux_arb_reg.sv
// N-channel arbitrating mux with a one-entry registered output stage.
// Define MUX_ARB_REG_RR_EN for round-robin arbitration; otherwise lowest index wins.
module mux_arb_reg
    import mux_arb_reg_pkg::*;
#(
    parameter int N_CH  = DEFAULT_N_CH,
    parameter int WIDTH = ARCH_WIDTH,
    parameter int SEL_W = clog2(N_CH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [N_CH-1:0]       in_valid,
    input  logic [N_CH*WIDTH-1:0] in_data,
    output logic [N_CH-1:0]       in_ready,
    input  logic                  force_en,
    input  logic [SEL_W-1:0]      force_sel,
    output logic                  out_valid,
    output logic [WIDTH-1:0]      out_data,
    output logic [SEL_W-1:0]      out_sel,
    input  logic                  out_ready
);

    // Handshake: a channel transfers when in_valid & in_ready; the output is
    // consumed when out_valid & out_ready; the register reloads when empty or draining.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SEL_W-1:0] out_sel_q,   out_sel_d;

    logic [N_CH-1:0]  force_mask;
    logic [N_CH-1:0]  elig;
    logic [N_CH-1:0]  grant;
    logic [SEL_W-1:0] grant_idx;
    logic [SEL_W-1:0] arb_ptr;
    logic [WIDTH-1:0] mux_data;
    logic             load;
    logic             xfer;

    // An out-of-range forced index selects nothing.
    always_comb begin
        force_mask = '0;
        if ({1'b0, force_sel} < (SEL_W+1)'(N_CH)) begin
            force_mask[force_sel] = 1'b1;
        end
    end

    assign elig     = force_en ? (in_valid & force_mask) : in_valid;
    assign load     = ~out_valid_q | out_ready;
    assign in_ready = grant & {N_CH{load & rst_n}};
    assign xfer     = |(in_valid & in_ready);

    mux_arb_grant #(
        .N_CH  (N_CH),
        .SEL_W (SEL_W)
    ) u_grant (
        .elig_i  (elig),
        .ptr_i   (arb_ptr),
        .grant_o (grant),
        .idx_o   (grant_idx)
    );

`ifdef MUX_ARB_REG_RR_EN
    logic [SEL_W-1:0] rr_ptr_q, rr_ptr_d;

    // Forced transfers do not disturb the fairness rotation.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer && !force_en) begin
            rr_ptr_d = (grant_idx == SEL_W'(N_CH - 1)) ? '0 : grant_idx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign arb_ptr = rr_ptr_q;
`else
    assign arb_ptr = '0;
`endif

    always_comb begin
        mux_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            mux_data = mux_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant[i]}});
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = mux_data;
            out_sel_d   = grant_idx;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;

endmodule
